// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller, datapath and immediate generator.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_B  = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_LWSW = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // One cycle's worth of datapath control; all-zero is the idle word.
    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       adr_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] imm_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] alu_ctl;
        logic [1:0] result_src;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7 to an ALU operation for R- and I-type instructions.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [2:0] ALUControl,
    output logic       unsupported
);

    always_comb begin
        ALUControl  = ALU_ADD;
        unsupported = 1'b0;
        case (funct3)
            // I-type reuses the funct7 field as immediate bits, so sub is R-type only
            F3_ADD:  ALUControl = (opcode == OP_R && funct7[5]) ? ALU_SUB : ALU_ADD;
            F3_SLT:  ALUControl = ALU_SLT;
            F3_OR:   ALUControl = ALU_OR;
            F3_AND:  ALUControl = ALU_AND;
            default: unsupported = 1'b1;
        endcase
        if (opcode == OP_R && funct7 != F7_BASE && funct7 != F7_ALT)
            unsupported = 1'b1;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences the shared datapath, stalls on MemReady, counts retirements.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic [1:0]  ResultSrc,
    output logic        Illegal,
    output logic [31:0] InstRet
);

    state_t      state, state_next;
    ctrl_t       ctl;
    logic        retire;
    logic        illegal_op;
    logic        alu_unsup;
    logic [2:0]  alu_op;
    logic [31:0] instret_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr;

    assign opcode       = Instr[6:0];
    assign funct3       = Instr[14:12];
    assign funct7       = Instr[31:25];
    assign unused_instr = ^{Instr[24:15], Instr[11:7]};

    alu_decoder u_alu_dec (
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .ALUControl  (alu_op),
        .unsupported (alu_unsup)
    );

    always_comb begin
        illegal_op = 1'b1;
        case (opcode)
            OP_LW, OP_SW: illegal_op = (funct3 != F3_LWSW);
            OP_R, OP_I:   illegal_op = alu_unsup;
            OP_B:         illegal_op = !(funct3 == F3_BEQ || funct3 == F3_BNE);
            default:      illegal_op = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    // Everything stays at the idle word while rst is high, including FETCH's read request.
    always_comb begin
        state_next = state;
        ctl        = '0;
        retire     = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    ctl.mem_read = 1'b1;
                    if (MemReady) begin
                        ctl.ir_write   = 1'b1;
                        ctl.pc_write   = 1'b1;
                        ctl.src_a      = SRCA_PC;
                        ctl.src_b      = SRCB_FOUR;
                        ctl.alu_ctl    = ALU_ADD;
                        ctl.result_src = RES_ALU;
                        state_next     = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Branch target goes to ALUOut now, while the ALU is otherwise idle
                    ctl.src_a   = SRCA_OLDPC;
                    ctl.src_b   = SRCB_IMM;
                    ctl.imm_src = IMM_B;
                    ctl.alu_ctl = ALU_ADD;
                    case (opcode)
                        OP_LW, OP_SW: state_next = S_MEMADR;
                        OP_R:         state_next = S_EXECR;
                        OP_I:         state_next = S_EXECI;
                        OP_B:         state_next = S_BRANCH;
                        default:      state_next = S_TRAP;
                    endcase
                    if (illegal_op) state_next = S_TRAP;
                end
                S_MEMADR: begin
                    ctl.src_a   = SRCA_RS1;
                    ctl.src_b   = SRCB_IMM;
                    ctl.imm_src = (opcode == OP_SW) ? IMM_S : IMM_I;
                    state_next  = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    ctl.adr_src  = 1'b1;
                    ctl.mem_read = 1'b1;
                    if (MemReady) state_next = S_MEMWB;
                end
                S_MEMWB: begin
                    ctl.result_src = RES_RDATA;
                    ctl.reg_write  = 1'b1;
                    retire         = 1'b1;
                    state_next     = S_FETCH;
                end
                S_MEMWRITE: begin
                    ctl.adr_src   = 1'b1;
                    ctl.mem_write = 1'b1;
                    if (MemReady) begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                end
                S_EXECR: begin
                    ctl.src_a   = SRCA_RS1;
                    ctl.src_b   = SRCB_RS2;
                    ctl.alu_ctl = alu_op;
                    state_next  = S_ALUWB;
                end
                S_EXECI: begin
                    ctl.src_a   = SRCA_RS1;
                    ctl.src_b   = SRCB_IMM;
                    ctl.imm_src = IMM_I;
                    ctl.alu_ctl = alu_op;
                    state_next  = S_ALUWB;
                end
                S_ALUWB: begin
                    ctl.result_src = RES_ALUOUT;
                    ctl.reg_write  = 1'b1;
                    retire         = 1'b1;
                    state_next     = S_FETCH;
                end
                S_BRANCH: begin
                    ctl.src_a      = SRCA_RS1;
                    ctl.src_b      = SRCB_RS2;
                    ctl.alu_ctl    = ALU_SUB;
                    ctl.result_src = RES_ALUOUT;
                    ctl.pc_write   = (funct3 == F3_BEQ && Zero) || (funct3 == F3_BNE && !Zero);
                    retire         = 1'b1;
                    state_next     = S_FETCH;
                end
                S_TRAP: begin
                    ctl.illegal = 1'b1;
                end
                default: state_next = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         instret_q <= '0;
        else if (retire) instret_q <= instret_q + 32'd1;
    end

    assign PCWrite    = ctl.pc_write;
    assign IRWrite    = ctl.ir_write;
    assign AdrSrc     = ctl.adr_src;
    assign MemRead    = ctl.mem_read;
    assign MemWrite   = ctl.mem_write;
    assign RegWrite   = ctl.reg_write;
    assign ImmSrc     = ctl.imm_src;
    assign ALUSrcA    = ctl.src_a;
    assign ALUSrcB    = ctl.src_b;
    assign ALUControl = ctl.alu_ctl;
    assign ResultSrc  = ctl.result_src;
    assign Illegal    = ctl.illegal;
    assign InstRet    = instret_q;

endmodule
